// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR sequencing controller.
package fir_pkg;

   localparam int unsigned TAP_NUM    = 11;
   localparam int unsigned WORD_BYTES = 4;

   localparam logic [11:0] AP_CTRL  = 12'h30;
   localparam logic [11:0] DATA_LEN = 12'h34;
   localparam logic [11:0] TAP_BASE = 12'h00;

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StWaitIn,
      StMac,
      StDrain,
      StOut,
      StDone
   } state_e;

endpackage

// File: rtl/fir_ctrl_if.sv
// Stream handshakes plus tap/data BRAM and MAC control between fir_ctrl and its datapath.
interface fir_ctrl_if #(
   parameter int unsigned pADDR_WIDTH = 12
);
   logic                   ss_tvalid;
   logic                   ss_tlast;
   logic                   ss_tready;
   logic                   sm_tready;
   logic                   sm_tvalid;
   logic                   sm_tlast;
   logic                   data_EN;
   logic [3:0]             data_WE;
   logic [pADDR_WIDTH-1:0] data_A;
   logic                   data_zero;
   logic                   tap_EN;
   logic [pADDR_WIDTH-1:0] tap_A;
   logic                   mac_clr;
   logic                   mac_en;

   modport master (
      input  ss_tvalid, ss_tlast, sm_tready,
      output ss_tready, sm_tvalid, sm_tlast, data_EN, data_WE, data_A, data_zero,
             tap_EN, tap_A, mac_clr, mac_en
   );

   modport slave (
      output ss_tvalid, ss_tlast, sm_tready,
      input  ss_tready, sm_tvalid, sm_tlast, data_EN, data_WE, data_A, data_zero,
             tap_EN, tap_A, mac_clr, mac_en
   );

endinterface

// File: rtl/fir_ring_ptr.sv
// Circular-buffer head pointer modulo TapNum and the (head - k) mod TapNum read index.
module fir_ring_ptr #(
   parameter  int unsigned TapNum = 11,
   localparam int unsigned IdxW   = $clog2(TapNum)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clr_i,
   input  logic            inc_i,
   input  logic [IdxW-1:0] k_i,
   output logic [IdxW-1:0] head_o,
   output logic [IdxW-1:0] idx_o
);
   localparam logic [IdxW-1:0] Last = IdxW'(TapNum - 1);
   localparam logic [IdxW-1:0] Wrap = IdxW'(TapNum);

   logic [IdxW-1:0] head_q, head_d;

   always_comb begin
      head_d = head_q;
      if (clr_i) begin
         head_d = '0;
      end else if (inc_i) begin
         head_d = (head_q == Last) ? '0 : head_q + IdxW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         head_q <= '0;
      end else begin
         head_q <= head_d;
      end
   end

   // Intermediate sum may exceed IdxW bits; modular wrap still yields the right index.
   assign idx_o  = (head_q >= k_i) ? head_q - k_i : head_q + Wrap - k_i;
   assign head_o = head_q;

endmodule

// File: rtl/fir_ctrl.sv
// FIR sequencing controller: ap_* protocol, stream handshakes, BRAM addressing, MAC control.
// Define FIR_CTRL_TLAST_CHECK_EN to add the sticky tlast_err output.
module fir_ctrl
   import fir_pkg::*;
#(
   parameter int unsigned pADDR_WIDTH = 12,
   parameter int unsigned Tape_Num    = TAP_NUM,
   parameter int unsigned pLEN_WIDTH  = 32
) (
   input  logic                  axis_clk,
   input  logic                  axis_rst_n,
   input  logic                  ap_start,
   input  logic                  ap_done_clr,
   input  logic [pLEN_WIDTH-1:0] data_length,
   output logic                  ap_done,
   output logic                  ap_idle,
`ifdef FIR_CTRL_TLAST_CHECK_EN
   output logic                  tlast_err,
`endif
   fir_ctrl_if.master            bus
);
   localparam int unsigned     IdxW  = $clog2(Tape_Num);
   localparam logic [IdxW-1:0] KLast = IdxW'(Tape_Num - 1);

   state_e                state_q, state_d;
   logic [IdxW-1:0]       k_q, k_d;
   logic [pLEN_WIDTH-1:0] len_q, len_d;
   logic [pLEN_WIDTH-1:0] cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic                  head_clr, head_inc;
   logic [IdxW-1:0]       head, ring_idx;
   logic                  is_last, start_acc, in_acc;

   fir_ring_ptr #(
      .TapNum(Tape_Num)
   ) u_ring (
      .clk_i (axis_clk),
      .rst_ni(axis_rst_n),
      .clr_i (head_clr),
      .inc_i (head_inc),
      .k_i   (k_q),
      .head_o(head),
      .idx_o (ring_idx)
   );

   function automatic logic [pADDR_WIDTH-1:0] byte_addr(logic [IdxW-1:0] idx);
      return pADDR_WIDTH'(idx) * pADDR_WIDTH'(WORD_BYTES);
   endfunction

   // cnt never passes len-1 while compared, so len=all-ones cannot overflow it.
   assign is_last = (cnt_q == len_q - pLEN_WIDTH'(1));

   always_comb begin
      state_d       = state_q;
      k_d           = k_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      head_clr      = 1'b0;
      head_inc      = 1'b0;
      start_acc     = 1'b0;
      in_acc        = 1'b0;
      ap_idle       = 1'b0;
      bus.ss_tready = 1'b0;
      bus.sm_tvalid = 1'b0;
      bus.sm_tlast  = 1'b0;
      bus.data_EN   = 1'b0;
      bus.data_WE   = 4'h0;
      bus.data_A    = '0;
      bus.data_zero = 1'b0;
      bus.tap_EN    = 1'b0;
      bus.tap_A     = '0;
      bus.mac_clr   = 1'b0;
      bus.mac_en    = 1'b0;

      unique case (state_q)
         StIdle: begin
            ap_idle = 1'b1;
            if (ap_start) begin
               start_acc = 1'b1;
               len_d     = data_length;
               k_d       = '0;
               state_d   = StInit;
            end
         end
         StInit: begin
            bus.data_EN   = 1'b1;
            bus.data_WE   = 4'hF;
            bus.data_zero = 1'b1;
            bus.data_A    = byte_addr(k_q);
            if (k_q == KLast) begin
               k_d      = '0;
               cnt_d    = '0;
               head_clr = 1'b1;
               state_d  = (len_q == '0) ? StDone : StWaitIn;
            end else begin
               k_d = k_q + IdxW'(1);
            end
         end
         StWaitIn: begin
            bus.ss_tready = 1'b1;
            if (bus.ss_tvalid) begin
               in_acc      = 1'b1;
               bus.data_EN = 1'b1;
               bus.data_WE = 4'hF;
               bus.data_A  = byte_addr(head);
               k_d         = '0;
               state_d     = StMac;
            end
         end
         StMac: begin
            bus.tap_EN  = 1'b1;
            bus.data_EN = 1'b1;
            bus.tap_A   = byte_addr(k_q);
            bus.data_A  = byte_addr(ring_idx);
            // Products appear one cycle after each read issue.
            bus.mac_en  = (k_q != '0);
            bus.mac_clr = (k_q == IdxW'(1));
            if (k_q == KLast) begin
               state_d = StDrain;
            end else begin
               k_d = k_q + IdxW'(1);
            end
         end
         StDrain: begin
            bus.mac_en = 1'b1;
            state_d    = StOut;
         end
         StOut: begin
            bus.sm_tvalid = 1'b1;
            bus.sm_tlast  = is_last;
            if (bus.sm_tready) begin
               head_inc = 1'b1;
               cnt_d    = cnt_q + pLEN_WIDTH'(1);
               state_d  = is_last ? StDone : StWaitIn;
            end
         end
         StDone: begin
            ap_idle = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Entering DONE beats a coincident clear.
      done_d = done_q;
      if (ap_done_clr || start_acc) done_d = 1'b0;
      if (state_d == StDone) done_d = 1'b1;
   end

   always_ff @(posedge axis_clk) begin
      if (!axis_rst_n) begin
         state_q <= StIdle;
         k_q     <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign ap_done = done_q;

`ifdef FIR_CTRL_TLAST_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (start_acc) begin
         err_d = 1'b0;
      end else if (in_acc && (bus.ss_tlast != is_last)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge axis_clk) begin
      if (!axis_rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign tlast_err = err_q;
`endif

endmodule

// File: tb/tb_fir_ctrl.sv
// Self-checking bench for fir_ctrl: protocol vector table, directed corner cases, random jobs.
module tb_fir_ctrl;
   import fir_pkg::*;

   localparam int unsigned AW = 12;
   localparam int unsigned LW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ap_start = 1'b0;
   logic          ap_done_clr = 1'b0;
   logic [LW-1:0] data_length = '0;
   logic          ap_done, ap_idle;
`ifdef FIR_CTRL_TLAST_CHECK_EN
   logic          tlast_err;
`endif

   fir_ctrl_if #(.pADDR_WIDTH(AW)) bus ();

   fir_ctrl #(
      .pADDR_WIDTH(AW),
      .Tape_Num   (11),
      .pLEN_WIDTH (LW)
   ) dut (
      .axis_clk   (clk),
      .axis_rst_n (rst_n),
      .ap_start   (ap_start),
      .ap_done_clr(ap_done_clr),
      .data_length(data_length),
      .ap_done    (ap_done),
      .ap_idle    (ap_idle),
`ifdef FIR_CTRL_TLAST_CHECK_EN
      .tlast_err  (tlast_err),
`endif
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit    rst;
      bit    start;
      bit    clr;
      int    len;
      int    waits;
      bit    exp_idle;
      bit    exp_done;
      string name;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs[NV];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_quiet(input string name);
      check(name, {bus.ss_tready, bus.sm_tvalid, bus.sm_tlast, bus.data_EN, bus.data_WE,
                   bus.data_A, bus.data_zero, bus.tap_EN, bus.tap_A, bus.mac_clr, bus.mac_en}, 0);
   endtask

   // Model: sample n of a job lives at word n mod 11; tap k pairs with word (n - k) mod 11.
   task automatic run_job(input int len, input bit rnd, input int out_hold, input int poke_k,
                          input int tl_pos);
      bit err_exp = 1'b0;
      bit got;
      int h;
      ap_start    = 1'b1;
      data_length = len;
      #1;
      check("start_idle", ap_idle, 1);
      tick();
      ap_start = 1'b0;
      for (int i = 0; i < 11; i++) begin
         #1;
`ifdef FIR_CTRL_TLAST_CHECK_EN
         if (i == 0) check("err_cleared", tlast_err, 0);
`endif
         check("init_idle", ap_idle, 0);
         check("init_A", bus.data_A, 4 * i);
         check("init_wr", {bus.data_EN, bus.data_WE, bus.data_zero, bus.ss_tready}, 7'b1_1111_1_0);
         tick();
      end
      for (int n = 0; n < len; n++) begin
         h   = n % 11;
         got = 1'b0;
         for (int g = 0; g < 40 && !got; g++) begin
            bus.ss_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.ss_tlast  = (n == tl_pos);
            #1;
            check("in_ready", bus.ss_tready, 1);
            if (bus.ss_tvalid) begin
               got = 1'b1;
               check("in_A", bus.data_A, 4 * h);
               check("in_wr", {bus.data_EN, bus.data_WE, bus.data_zero}, 6'b1_1111_0);
               if ((n == tl_pos) != (n == len - 1)) err_exp = 1'b1;
            end
            tick();
         end
         bus.ss_tvalid = 1'b0;
         bus.ss_tlast  = 1'b0;
         if (!got) check("in_timeout", 0, 1);
         for (int k = 0; k < 11; k++) begin
            if (k == poke_k) begin
               ap_start    = 1'b1;
               data_length = len + 5;
            end
            #1;
            check("mac_tapA", bus.tap_A, 4 * k);
            check("mac_dataA", bus.data_A, 4 * ((h - k + 11) % 11));
            check("mac_ctl", {bus.tap_EN, bus.data_EN, bus.data_WE, bus.mac_en, bus.mac_clr,
                              bus.ss_tready, bus.sm_tvalid},
                  {2'b11, 4'h0, 1'(k != 0), 1'(k == 1), 2'b00});
            tick();
            ap_start = 1'b0;
         end
         #1;
         check("drain", {bus.mac_en, bus.mac_clr, bus.tap_EN, bus.sm_tvalid}, 4'b1000);
         tick();
         got = 1'b0;
         for (int g = 0; g < 40 && !got; g++) begin
            bus.sm_tready = rnd ? 1'($urandom_range(0, 1)) : 1'(g >= out_hold);
            #1;
            check("out_valid", bus.sm_tvalid, 1);
            check("out_last", bus.sm_tlast, n == len - 1);
            check("out_no_in", bus.ss_tready, 0);
            got = bus.sm_tready;
            tick();
         end
         bus.sm_tready = 1'b0;
         if (!got) check("out_timeout", 0, 1);
      end
      #1;
      check("done_flag", ap_done, 1);
      check("done_idle", ap_idle, 1);
`ifdef FIR_CTRL_TLAST_CHECK_EN
      check("tlast_err", tlast_err, err_exp);
`endif
      tick();
      #1;
      check("post_done", ap_done, 1);
      check("post_idle", ap_idle, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      int len;
      bus.ss_tvalid = 1'b0;
      bus.ss_tlast  = 1'b0;
      bus.sm_tready = 1'b0;

      // rst start clr len waits idle done
      vecs[0]  = '{1, 0, 0, 0, 0, 1, 0, "reset"};
      vecs[1]  = '{0, 0, 0, 0, 2, 1, 0, "idle"};
      vecs[2]  = '{0, 1, 0, 0, 0, 0, 0, "start_len0"};
      vecs[3]  = '{0, 0, 0, 0, 9, 0, 0, "init_end"};
      vecs[4]  = '{0, 0, 0, 0, 0, 1, 1, "done_state"};
      vecs[5]  = '{0, 0, 0, 0, 0, 1, 1, "done_sticky"};
      vecs[6]  = '{0, 0, 1, 0, 0, 1, 0, "clr"};
      vecs[7]  = '{0, 0, 1, 0, 0, 1, 0, "clr_noop"};
      vecs[8]  = '{0, 1, 0, 0, 0, 0, 0, "restart"};
      vecs[9]  = '{0, 0, 0, 0, 9, 0, 0, "init_end2"};
      vecs[10] = '{0, 0, 1, 0, 0, 1, 1, "set_beats_clr"};
      vecs[11] = '{0, 0, 0, 0, 0, 1, 1, "idle_done"};
      vecs[12] = '{0, 1, 0, 0, 0, 0, 0, "start_clears"};
      vecs[13] = '{0, 0, 0, 0, 4, 0, 0, "mid_init"};
      vecs[14] = '{1, 0, 0, 0, 0, 1, 0, "rst_mid_init"};
      vecs[15] = '{0, 0, 0, 0, 3, 1, 0, "stay_idle"};

      for (int i = 0; i < NV; i++) begin
         rst_n       = !vecs[i].rst;
         ap_start    = vecs[i].start;
         ap_done_clr = vecs[i].clr;
         data_length = vecs[i].len;
         tick();
         rst_n       = 1'b1;
         ap_start    = 1'b0;
         ap_done_clr = 1'b0;
         repeat (vecs[i].waits) tick();
         #1;
         check({vecs[i].name, "_idle"}, ap_idle, vecs[i].exp_idle);
         check({vecs[i].name, "_done"}, ap_done, vecs[i].exp_done);
         if (vecs[i].exp_idle) check_quiet({vecs[i].name, "_quiet"});
      end

      run_job(600, 1'b1, 0, -1, 599);
      run_job(1, 1'b0, 5, -1, 0);
      run_job(3, 1'b0, 0, -1, 2);
      ap_done_clr = 1'b1;
      tick();
      ap_done_clr = 1'b0;
      #1;
      check("clr_after_job_done", ap_done, 0);
      check("clr_after_job_idle", ap_idle, 1);
      run_job(2, 1'b0, 0, 3, 1);
      run_job(0, 1'b0, 0, -1, -1);

      // Reset in the middle of MAC.
      ap_start    = 1'b1;
      data_length = 5;
      tick();
      ap_start = 1'b0;
      repeat (11) tick();
      bus.ss_tvalid = 1'b1;
      tick();
      bus.ss_tvalid = 1'b0;
      repeat (4) tick();
      #1;
      check("mid_mac_en", bus.mac_en, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      check_quiet("rst_mac_quiet");
      check("rst_mac_idle", ap_idle, 1);
      check("rst_mac_done", ap_done, 0);
      tick();
      #1;
      check_quiet("rst_mac_stays");

      run_job(4, 1'b0, 0, -1, 1);
      run_job(2, 1'b0, 0, -1, 1);
      repeat (6) begin
         len = $urandom_range(1, 30);
         run_job(len, 1'b1, 0, -1, len - 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fir_ctrl.md
Name: fir_ctrl

Overview:
- Sequencing controller for the 11-tap FIR engine.
- Owns the ap_start/ap_done/ap_idle protocol and the AXI-Stream in/out handshakes.
- Generates tap-RAM and data-RAM addresses (data RAM used as a circular shift buffer), plus accumulator control for the MAC datapath.
- Sits between the AXI-lite config block (supplies ap_start and data_length) and the MAC/BRAM datapath.

Parameters:
pADDR_WIDTH, 12, BRAM byte-address width
Tape_Num, 11, number of taps and data-buffer depth (words)
pLEN_WIDTH, 32, width of data_length

Ports:
axis_clk  in  1  single clock for all logic
axis_rst_n  in  1  reset, synchronous, active-low
ap_start  in  1  one-cycle start pulse from config block (0x30 bit0 write)
ap_done_clr  in  1  pulse on AXI-lite read of 0x30; clears ap_done
data_length  in  pLEN_WIDTH  sample count, latched on accepted ap_start
ap_done  out  1  sticky done flag
ap_idle  out  1  engine idle
ss_tvalid  in  1  input stream valid
ss_tlast  in  1  input stream last
ss_tready  out  1  input stream ready
sm_tready  in  1  output stream ready
sm_tvalid  out  1  output stream valid
sm_tlast  out  1  output stream last
data_EN  out  1  data RAM enable
data_WE  out  4  data RAM byte write enables
data_A  out  pADDR_WIDTH  data RAM byte address
data_zero  out  1  datapath muxes 0 onto data_Di (else ss_tdata)
tap_EN  out  1  tap RAM enable for engine port
tap_A  out  pADDR_WIDTH  tap RAM byte address
mac_clr  out  1  load accumulator with product instead of adding
mac_en  out  1  accumulate the current tap_Do*data_Do product

Behaviour:
- Reset (axis_rst_n=0 at a clock edge):
  - State=IDLE; ap_idle=1; ap_done=0; all other outputs 0.
  - head=0, cnt=0.
  - Reset mid-operation aborts everything; no output is emitted.
- IDLE: ap_start=1 -> latch data_length into len, clear ap_done, go to INIT. ap_idle falls the next cycle.
- INIT (Tape_Num cycles, i=0..10):
  - data_EN=1, data_WE=4'hF, data_zero=1, data_A=4*i.
  - Then head=0, cnt=0.
  - If len==0, go to DONE; else go to WAIT_IN.
- WAIT_IN:
  - ss_tready=1.
  - On ss_tvalid & ss_tready: data_WE=4'hF, data_A=4*head (sample written), go to MAC.
  - ss_tready is 0 in every other state.
- MAC (Tape_Num issue cycles, k=0..10):
  - tap_EN=data_EN=1, tap_A=4*k, data_A=4*((head-k) mod Tape_Num); wrap from 0 to 10 when head<k.
  - BRAM read latency is 1 cycle, so mac_en is asserted in cycles k+1 (one cycle after each issue).
  - mac_clr is asserted together with the first mac_en.
  - After the last issue, spend 1 DRAIN cycle for the final mac_en, then go to OUT.
- OUT:
  - sm_tvalid=1, held stable until sm_tready.
  - sm_tlast=1 iff cnt==len-1.
  - On handshake: head=(head+1) mod Tape_Num, cnt++. If last, go to DONE; else go to WAIT_IN.
- Latency: input accept at cycle T -> mac_en at T+2..T+12 -> sm_tvalid at T+13 (with sm_tready=1).
- DONE: ap_done=1, ap_idle=1, go to IDLE the same cycle.
- ap_done behaviour:
  - Stays 1 until ap_done_clr or the next accepted ap_start.
  - ap_done_clr coincident with ap_done being set: the set wins.
- ap_start while not IDLE is ignored. ap_done_clr while ap_done=0 has no effect.
- ss_tlast is not used for termination; termination is by len only.
- Counters are pLEN_WIDTH wide. len=0xFFFFFFFF must not overflow cnt before the last compare.

Optional Feature:
- FIR_CTRL_TLAST_CHECK_EN defined:
  - Adds output tlast_err (1 bit, reset 0, sticky until next accepted ap_start).
  - tlast_err is set when an accepted input has ss_tlast != (cnt==len-1).
- Not defined: port absent, ss_tlast ignored.

Decomposition:
- Package fir_pkg:
  - State enum (IDLE, INIT, WAIT_IN, MAC, DRAIN, OUT, DONE).
  - TAP_NUM=11, WORD_BYTES=4.
  - Register offsets: AP_CTRL=12'h30, DATA_LEN=12'h34, TAP_BASE=12'h00.
- One sub-module, fir_ring_ptr: modulo-Tape_Num head register and (head-k) mod Tape_Num offset computation.

Test Plan:
- Reset, then ap_start with len=600 -> ap_idle=0 next cycle; INIT writes addresses 0..40 with WE=F, data_zero=1, over 11 cycles.
- Single sample accepted at T with head=0 -> data_A sequence 0,40,36,...,4 at T+1..T+11; mac_clr only at T+2; sm_tvalid at T+13.
- sm_tready held 0 for 5 cycles -> sm_tvalid stays 1, ss_tready stays 0; no state advance.
- len=3 -> sm_tlast only on 3rd output; then ap_done=1, ap_idle=1; ap_done_clr pulse -> ap_done=0 while ap_idle stays 1.
- ap_start during MAC -> ignored; len unchanged. axis_rst_n=0 mid-MAC -> IDLE next cycle, all outputs 0, ap_idle=1.
- With FIR_CTRL_TLAST_CHECK_EN: len=4, ss_tlast on 2nd sample -> tlast_err=1 and sticky; the next ap_start clears it.
